// File: rtl/demux_conductual_pkg.sv
// Shared constants and the channel-select encoding for the 1:2 buffered demultiplexer.
package demux_conductual_pkg;

    localparam int DEMUX_BW    = 2;
    localparam int DEMUX_DEPTH = 4;
    localparam int DEMUX_PTR   = 2;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_e;

endpackage

// File: rtl/demux_conductual_if.sv
// Push side (selector/valid/data/ready) and both consumer pop/valid channels plus status flags.
interface demux_conductual_if #(
    parameter int BW = demux_conductual_pkg::DEMUX_BW
);
    logic          selector;
    logic          valid_in;
    logic [BW-1:0] data_in;
    logic          ready_in;
    logic          pop_0;
    logic          pop_1;
    logic [BW-1:0] data_out0;
    logic [BW-1:0] data_out1;
    logic          valid_out0;
    logic          valid_out1;
    logic          full_0;
    logic          full_1;
    logic          empty_0;
    logic          empty_1;
    logic          err;

    modport master (
        output selector, valid_in, data_in, pop_0, pop_1,
        input  ready_in, data_out0, data_out1, valid_out0, valid_out1,
        input  full_0, full_1, empty_0, empty_1, err
    );

    modport slave (
        input  selector, valid_in, data_in, pop_0, pop_1,
        output ready_in, data_out0, data_out1, valid_out0, valid_out1,
        output full_0, full_1, empty_0, empty_1, err
    );
endinterface

// File: rtl/demux_conductual_fifo_sincrono.sv
// Per-channel synchronous FIFO with registered output word and one-cycle output-valid pulse.
module fifo_sincrono #(
    parameter int BW    = 2,
    parameter int DEPTH = 4,
    parameter int PTR   = 2
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          push,
    input  logic          pop,
    input  logic [BW-1:0] din,
    output logic [BW-1:0] dout,
    output logic          dout_valid,
    output logic          full,
    output logic          empty
);
    localparam logic [PTR:0] FULL_CNT = (PTR+1)'(DEPTH);

    logic [BW-1:0]  r_mem [DEPTH];
    logic [PTR-1:0] r_wr_ptr;
    logic [PTR-1:0] r_rd_ptr;
    logic [PTR:0]   r_count;
    logic [BW-1:0]  r_dout;
    logic           r_dout_valid;
    logic           w_do_push;
    logic           w_do_pop;

    assign full       = (r_count == FULL_CNT);
    assign empty      = (r_count == '0);
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

    // A pop on a full FIFO frees the slot the concurrent push reuses.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_do_pop;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_L && w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/demux_conductual.sv
// 1:2 demultiplexer: steers the input stream into one of two buffered channels by selector.
module demux_conductual
    import demux_conductual_pkg::*;
#(
    parameter int BW    = DEMUX_BW,
    parameter int DEPTH = DEMUX_DEPTH,
    parameter int PTR   = DEMUX_PTR
) (
    input  logic               clk,
    input  logic               reset_L,
    demux_conductual_if.slave  bus
);
    logic w_sel_ch1;
    logic w_full_sel;
    logic w_pop_sel;
    logic w_push_0;
    logic w_push_1;
    logic r_err;

    assign w_sel_ch1  = (chan_e'(bus.selector) == CH1);
    assign w_full_sel = w_sel_ch1 ? bus.full_1 : bus.full_0;
    assign w_pop_sel  = w_sel_ch1 ? bus.pop_1  : bus.pop_0;

    assign bus.ready_in = !w_full_sel;
    assign bus.err      = r_err;

    // Full channel still accepts a push when its consumer pops in the same cycle.
    assign w_push_0 = bus.valid_in && !w_sel_ch1 && (!bus.full_0 || bus.pop_0);
    assign w_push_1 = bus.valid_in &&  w_sel_ch1 && (!bus.full_1 || bus.pop_1);

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_err <= 1'b0;
        end else if (bus.valid_in && w_full_sel && !w_pop_sel) begin
            r_err <= 1'b1;
        end
    end

    fifo_sincrono #(.BW(BW), .DEPTH(DEPTH), .PTR(PTR)) u_fifo_0 (
        .clk        (clk),
        .reset_L    (reset_L),
        .push       (w_push_0),
        .pop        (bus.pop_0),
        .din        (bus.data_in),
        .dout       (bus.data_out0),
        .dout_valid (bus.valid_out0),
        .full       (bus.full_0),
        .empty      (bus.empty_0)
    );

    fifo_sincrono #(.BW(BW), .DEPTH(DEPTH), .PTR(PTR)) u_fifo_1 (
        .clk        (clk),
        .reset_L    (reset_L),
        .push       (w_push_1),
        .pop        (bus.pop_1),
        .din        (bus.data_in),
        .dout       (bus.data_out1),
        .dout_valid (bus.valid_out1),
        .full       (bus.full_1),
        .empty      (bus.empty_1)
    );

endmodule

// File: tb/tb_demux_conductual.sv
// Directed-vector bench for demux_conductual: routing, overflow, simultaneous push/pop, wrap, reset.
module tb_demux_conductual;
    logic clk;
    logic reset_L;
    int   total;
    int   bad;

    demux_conductual_if bus ();

    demux_conductual dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.selector = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = 2'b00;
        bus.pop_0    = 1'b0;
        bus.pop_1    = 1'b0;
    endtask

    task automatic push_word(input logic sel, input logic [1:0] d);
        bus.selector = sel;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in  = 2'b11;
        bus.pop_0    = 1'b1;
        tick();
        tick();
        idle_inputs();
        #1;
        total++; if (bus.data_out0 !== 2'b00) begin bad++; $display("FAIL rst_d0 got=%b exp=00", bus.data_out0); end
        total++; if (bus.data_out1 !== 2'b00) begin bad++; $display("FAIL rst_d1 got=%b exp=00", bus.data_out1); end
        total++; if ({bus.valid_out0, bus.valid_out1} !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b exp=00", {bus.valid_out0, bus.valid_out1}); end
        total++; if ({bus.empty_0, bus.empty_1} !== 2'b11) begin bad++; $display("FAIL rst_empty got=%b exp=11", {bus.empty_0, bus.empty_1}); end
        total++; if ({bus.full_0, bus.full_1} !== 2'b00) begin bad++; $display("FAIL rst_full got=%b exp=00", {bus.full_0, bus.full_1}); end
        total++; if (bus.ready_in !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.ready_in); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err); end
        reset_L = 1'b1;
        tick();
        tick();
        total++; if ({bus.valid_out0, bus.valid_out1} !== 2'b00) begin bad++; $display("FAIL idle_valid got=%b exp=00", {bus.valid_out0, bus.valid_out1}); end
    endtask

    task automatic test_routing();
        push_word(1'b0, 2'b01);
        push_word(1'b1, 2'b10);
        push_word(1'b0, 2'b11);
        total++; if ({bus.empty_0, bus.empty_1} !== 2'b00) begin bad++; $display("FAIL route_empty got=%b exp=00", {bus.empty_0, bus.empty_1}); end
        bus.pop_0 = 1'b1;
        tick();
        total++; if ({bus.valid_out0, bus.data_out0, bus.valid_out1} !== 4'b1010) begin bad++; $display("FAIL route_pop0a got=%b exp=1010", {bus.valid_out0, bus.data_out0, bus.valid_out1}); end
        tick();
        total++; if ({bus.valid_out0, bus.data_out0} !== 3'b111) begin bad++; $display("FAIL route_pop0b got=%b exp=111", {bus.valid_out0, bus.data_out0}); end
        bus.pop_0 = 1'b0;
        bus.pop_1 = 1'b1;
        tick();
        total++; if ({bus.valid_out0, bus.data_out0} !== 3'b011) begin bad++; $display("FAIL route_hold0 got=%b exp=011", {bus.valid_out0, bus.data_out0}); end
        total++; if ({bus.valid_out1, bus.data_out1} !== 3'b110) begin bad++; $display("FAIL route_pop1 got=%b exp=110", {bus.valid_out1, bus.data_out1}); end
        bus.pop_1 = 1'b0;
        tick();
        total++; if (bus.valid_out1 !== 1'b0) begin bad++; $display("FAIL route_pulse1 got=%b exp=0", bus.valid_out1); end
        total++; if ({bus.empty_0, bus.empty_1} !== 2'b11) begin bad++; $display("FAIL route_drained got=%b exp=11", {bus.empty_0, bus.empty_1}); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) push_word(1'b0, 2'(i));
        total++; if (bus.full_0 !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=1", bus.full_0); end
        total++; if (bus.ready_in !== 1'b0) begin bad++; $display("FAIL ovf_ready0 got=%b exp=0", bus.ready_in); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL ovf_err_pre got=%b exp=0", bus.err); end
        push_word(1'b0, 2'b10);
        total++; if ({bus.err, bus.full_0} !== 2'b11) begin bad++; $display("FAIL ovf_err got=%b exp=11", {bus.err, bus.full_0}); end
        bus.selector = 1'b1;
        #1;
        total++; if (bus.ready_in !== 1'b1) begin bad++; $display("FAIL ovf_ready1 got=%b exp=1", bus.ready_in); end
        push_word(1'b1, 2'b11);
        total++; if ({bus.empty_1, bus.err} !== 2'b01) begin bad++; $display("FAIL ovf_ch1_push got=%b exp=01", {bus.empty_1, bus.err}); end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_q [4];
        exp_q = '{2'd2, 2'd1, 2'd0, 2'd1};
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        push_word(1'b0, 2'd3);
        push_word(1'b0, 2'd2);
        push_word(1'b0, 2'd1);
        push_word(1'b0, 2'd0);
        bus.pop_0 = 1'b1;
        push_word(1'b0, 2'd1);
        bus.pop_0 = 1'b0;
        total++; if ({bus.valid_out0, bus.data_out0} !== 3'b111) begin bad++; $display("FAIL sim_full_pop got=%b exp=111", {bus.valid_out0, bus.data_out0}); end
        total++; if ({bus.full_0, bus.err} !== 2'b10) begin bad++; $display("FAIL sim_full_state got=%b exp=10", {bus.full_0, bus.err}); end
        bus.pop_1 = 1'b1;
        push_word(1'b1, 2'd2);
        bus.pop_1 = 1'b0;
        total++; if ({bus.valid_out1, bus.empty_1} !== 2'b00) begin bad++; $display("FAIL sim_empty_pp got=%b exp=00", {bus.valid_out1, bus.empty_1}); end
        bus.pop_0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if ({bus.valid_out0, bus.data_out0} !== {1'b1, exp_q[i]}) begin bad++; $display("FAIL sim_drain%0d got=%b exp=%b", i, {bus.valid_out0, bus.data_out0}, {1'b1, exp_q[i]}); end
        end
        bus.pop_0 = 1'b0;
        total++; if (bus.empty_0 !== 1'b1) begin bad++; $display("FAIL sim_empty0 got=%b exp=1", bus.empty_0); end
        bus.pop_1 = 1'b1;
        tick();
        bus.pop_1 = 1'b0;
        total++; if ({bus.valid_out1, bus.data_out1} !== 3'b110) begin bad++; $display("FAIL sim_pop1 got=%b exp=110", {bus.valid_out1, bus.data_out1}); end
    endtask

    task automatic test_wrap();
        logic [1:0] v;
        bus.selector = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = 2'(i % 4);
            bus.valid_in = 1'b1;
            bus.data_in  = v;
            bus.pop_1    = (i != 0);
            tick();
            if (i > 0) begin
                total++; if ({bus.valid_out1, bus.data_out1} !== {1'b1, 2'((i - 1) % 4)}) begin bad++; $display("FAIL wrap%0d got=%b exp=%b", i, {bus.valid_out1, bus.data_out1}, {1'b1, 2'((i - 1) % 4)}); end
            end
            total++; if ({bus.empty_1, bus.full_1} !== 2'b00) begin bad++; $display("FAIL wrap_flags%0d got=%b exp=00", i, {bus.empty_1, bus.full_1}); end
        end
        bus.valid_in = 1'b0;
        tick();
        bus.pop_1 = 1'b0;
        total++; if ({bus.valid_out1, bus.data_out1, bus.empty_1} !== 4'b1011) begin bad++; $display("FAIL wrap_last got=%b exp=1011", {bus.valid_out1, bus.data_out1, bus.empty_1}); end
    endtask

    task automatic test_reset_midstream();
        push_word(1'b0, 2'd1);
        push_word(1'b0, 2'd2);
        push_word(1'b0, 2'd3);
        for (int i = 0; i < 5; i++) push_word(1'b1, 2'd3);
        total++; if ({bus.err, bus.empty_0} !== 2'b10) begin bad++; $display("FAIL mid_pre got=%b exp=10", {bus.err, bus.empty_0}); end
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        total++; if ({bus.empty_0, bus.empty_1, bus.err} !== 3'b110) begin bad++; $display("FAIL mid_rst got=%b exp=110", {bus.empty_0, bus.empty_1, bus.err}); end
        bus.pop_0 = 1'b1;
        bus.pop_1 = 1'b1;
        tick();
        bus.pop_0 = 1'b0;
        bus.pop_1 = 1'b0;
        total++; if ({bus.valid_out0, bus.valid_out1, bus.data_out0} !== 4'b0000) begin bad++; $display("FAIL mid_nopop got=%b exp=0000", {bus.valid_out0, bus.valid_out1, bus.data_out0}); end
        push_word(1'b0, 2'd2);
        bus.pop_0 = 1'b1;
        tick();
        total++; if ({bus.valid_out0, bus.data_out0} !== 3'b110) begin bad++; $display("FAIL mid_new got=%b exp=110", {bus.valid_out0, bus.data_out0}); end
        tick();
        bus.pop_0 = 1'b0;
        total++; if ({bus.valid_out0, bus.empty_0} !== 2'b01) begin bad++; $display("FAIL mid_only got=%b exp=01", {bus.valid_out0, bus.empty_0}); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_L = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_routing();
        test_overflow();
        test_simultaneous();
        test_wrap();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
